// File: rtl/sobel_stream_engine.sv
// ---------------------------------------------------------------------------
// sobel_stream_engine
// Streaming 3x3 Sobel engine. RGB pixels arrive unpadded in raster order, are
// converted to grayscale, and pass through two line buffers and a 3x3 window.
// Zero padding at the frame border comes from the centre row/column counters,
// so stale line-buffer contents never reach a result.
//
// Optional feature macro: SOBEL_CLAMP_EN. When it is defined, modes 00/01/10
// output |G| saturated to 0..2^PIX_W-1. Bypass mode is unaffected.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode[1:0]           00 Gx, 01 Gy, 10 |Gx|+|Gy|, 11 gray bypass (latched at sof)
//   in_valid/in_ready   pixel handshake (in_ready low only while flushing)
//   in_sof              first pixel of a frame
//   R, G, B             colour channels, PIX_W bits each
//   out_valid, Y        one result per pixel, raster order, no backpressure
//   out_sof, out_eof    first/last result of a frame
//   busy                frame in progress
// ---------------------------------------------------------------------------
module sobel_stream_engine #(
    parameter int IMG_W = 480,
    parameter int IMG_H = 360,
    parameter int PIX_W = 8,
    parameter int OUT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] R,
    input  logic [PIX_W-1:0] G,
    input  logic [PIX_W-1:0] B,
    output logic             out_valid,
    output logic [OUT_W-1:0] Y,
    output logic             out_sof,
    output logic             out_eof,
    output logic             busy
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = $clog2(IMG_H + 2);
    localparam int SW = PIX_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IMG_H + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    function automatic logic [PIX_W-1:0] to_gray(input logic [PIX_W-1:0] r,
                                                 input logic [PIX_W-1:0] g,
                                                 input logic [PIX_W-1:0] b);
        logic [PIX_W+8:0] acc;
        acc = (PIX_W+9)'(r) * (PIX_W+9)'(77) + (PIX_W+9)'(g) * (PIX_W+9)'(150)
            + (PIX_W+9)'(b) * (PIX_W+9)'(29);
        return acc[PIX_W+7:8];
    endfunction

    function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic [SW-1:0] abs_val(input logic signed [SW-1:0] v);
        return v[SW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_pix(input logic [SW-1:0] m);
        return (|m[SW-1:PIX_W]) ? {PIX_W{1'b1}} : m[PIX_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] shape(input logic [1:0] m,
                                               input logic signed [SW-1:0] gx,
                                               input logic signed [SW-1:0] gy,
                                               input logic [PIX_W-1:0] ctr);
        logic [SW-1:0] mag;
        mag = abs_val(gx) + abs_val(gy);
        case (m)
`ifdef SOBEL_CLAMP_EN
            2'b00:   return OUT_W'(sat_pix(abs_val(gx)));
            2'b01:   return OUT_W'(sat_pix(abs_val(gy)));
            2'b10:   return OUT_W'(sat_pix(mag));
`else
            2'b00:   return OUT_W'(gx);
            2'b01:   return OUT_W'(gy);
            2'b10:   return OUT_W'(mag);
`endif
            default: return OUT_W'(ctr);
        endcase
    endfunction

    logic [1:0]    state, mode_q;
    logic [RW-1:0] row_i, cur_row, nxt_row, row_c;
    logic [CW-1:0] col_i, cur_col, nxt_col, col_c;
    logic          acc_pix, sof_acc, tick, adv, emit, abort;

    // The advancing index is forced to 0 by an accepted sof; flush ticks keep
    // counting past the frame so the last row/column windows complete.
    always_comb begin
        acc_pix = in_valid & in_ready;
        sof_acc = acc_pix & in_sof;
        tick    = (state == S_FLUSH);
        adv     = tick | (acc_pix & ((state != S_IDLE) | in_sof));
        abort   = sof_acc & ((state == S_FILL) | (state == S_RUN));
        cur_row = sof_acc ? '0 : row_i;
        cur_col = sof_acc ? '0 : col_i;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = cur_row + RW'(1);
        end else begin
            nxt_col = cur_col + CW'(1);
            nxt_row = cur_row;
        end
        emit = adv & ((cur_row > RW'(1)) | ((cur_row == RW'(1)) & (cur_col != '0)));
    end

    assign in_ready = (state != S_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            row_i  <= '0;
            col_i  <= '0;
            row_c  <= '0;
            col_c  <= '0;
            mode_q <= 2'b00;
        end else begin
            if (adv) begin
                row_i <= nxt_row;
                col_i <= nxt_col;
            end
            if (sof_acc) begin
                mode_q <= mode;
                row_c  <= '0;
                col_c  <= '0;
            end else if (emit) begin
                if (col_c == COL_LAST) begin
                    col_c <= '0;
                    row_c <= row_c + RW'(1);
                end else begin
                    col_c <= col_c + CW'(1);
                end
            end
            case (state)
                S_IDLE:  if (sof_acc) state <= S_FILL;
                S_FILL:  if (sof_acc) state <= S_FILL;
                         else if (adv && cur_row == RW'(1) && cur_col == CW'(1)) state <= S_RUN;
                S_RUN:   if (sof_acc) state <= S_FILL;
                         else if (adv && cur_row == ROW_LAST && cur_col == COL_LAST) state <= S_FLUSH;
                default: if (cur_row == ROW_END) state <= S_IDLE;
            endcase
        end
    end

    // ---- stage p0: grayscale register, padding mask of the emitted centre
    logic             vld_p0, emit_p0, sof_p0, eof_p0;
    logic [PIX_W-1:0] g_p0;
    logic [CW-1:0]    col_p0;
    logic [3:0]       msk_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            emit_p0 <= 1'b0;
        end else begin
            vld_p0  <= adv;
            emit_p0 <= emit;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            g_p0   <= tick ? '0 : to_gray(R, G, B);
            col_p0 <= cur_col;
            // {top, bottom, left, right} neighbour rows/columns lie outside
            msk_p0 <= {row_c == '0, row_c == ROW_LAST, col_c == '0, col_c == COL_LAST};
            sof_p0 <= (row_c == '0) && (col_c == '0);
            eof_p0 <= (row_c == ROW_LAST) && (col_c == COL_LAST);
        end
    end

    // ---- stage p1: line buffers and 3x3 window shift (newest column = 2)
    logic             emit_p1, sof_p1, eof_p1;
    logic [3:0]       msk_p1;
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] win [3][3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) emit_p1 <= 1'b0;
        else        emit_p1 <= emit_p0 & ~abort;
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2]   <= lb2[col_p0];
            win[1][2]   <= lb1[col_p0];
            win[2][2]   <= g_p0;
            lb2[col_p0] <= lb1[col_p0];
            lb1[col_p0] <= g_p0;
            msk_p1      <= msk_p0;
            sof_p1      <= sof_p0;
            eof_p1      <= eof_p0;
        end
    end

    // ---- stage p2: padded kernel sums and output register
    logic [PIX_W-1:0]        tap [3][3];
    logic signed [SW-1:0]    gx, gy;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                tap[r][c] = win[r][c];
                if ((r == 0 && msk_p1[3]) || (r == 2 && msk_p1[2]) ||
                    (c == 0 && msk_p1[1]) || (c == 2 && msk_p1[0]))
                    tap[r][c] = '0;
            end
        end
        gx = (ext(tap[0][2]) + ext(tap[1][2]) + ext(tap[1][2]) + ext(tap[2][2]))
           - (ext(tap[0][0]) + ext(tap[1][0]) + ext(tap[1][0]) + ext(tap[2][0]));
        gy = (ext(tap[2][0]) + ext(tap[2][1]) + ext(tap[2][1]) + ext(tap[2][2]))
           - (ext(tap[0][0]) + ext(tap[0][1]) + ext(tap[0][1]) + ext(tap[0][2]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            Y         <= '0;
        end else begin
            out_valid <= emit_p1 & ~abort;
            out_sof   <= emit_p1 & ~abort & sof_p1;
            out_eof   <= emit_p1 & ~abort & eof_p1;
            if (emit_p1) Y <= shape(mode_q, gx, gy, win[1][1]);
        end
    end

    // Covers the drain after FLUSH returns to IDLE, up to the out_eof cycle.
    assign busy = (state != S_IDLE) | emit_p0 | emit_p1 | out_valid;

endmodule
